// File: rtl/btn_pkg.sv
// Shared definitions for the button event classifier: state encoding and the
// default timing constants (also used by the lab wrapper).
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } btn_state_e;

    // 0.5 s and 0.25 s at a 100 MHz system clock
    localparam int LONG_CYCLES_DEFAULT   = 50_000_000;
    localparam int DCLICK_CYCLES_DEFAULT = 25_000_000;

endpackage

// File: rtl/btn_cycle_timer.sv
// Consecutive-sample counter for the button classifier. It counts while enabled
// and holds at the terminal value; the FSM decides what the terminal means.
module btn_cycle_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_enable,
    input  logic [TW-1:0] i_terminal,
    output logic          o_at_terminal
);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != i_terminal)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_terminal = (r_count == i_terminal);

endmodule

// File: rtl/button_event_fsm.sv
// Classifies debounced button activity into short press, long press and double
// click, emitting one-cycle pulses and a wrapping event count.
module button_event_fsm
    import btn_pkg::*;
#(
    parameter int  LONG_CYCLES   = LONG_CYCLES_DEFAULT,
    parameter int  DCLICK_CYCLES = DCLICK_CYCLES_DEFAULT,
    localparam int TW            = $clog2(LONG_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_level,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic       pressed,
    output logic       busy,
    output logic [7:0] event_count
);

    // The sample that enters PRESS1/WAIT2/PRESS2 is the first of its run, so
    // the timer only has to count the remaining N-1 samples (terminal N-2).
    localparam logic [TW-1:0] LONG_TERM   = TW'(LONG_CYCLES - 2);
    localparam logic [TW-1:0] DCLICK_TERM = TW'(DCLICK_CYCLES - 2);

    btn_state_e    r_state;
    btn_state_e    w_state_next;
    logic          w_short;
    logic          w_long;
    logic          w_dclick;
    logic          w_timer_en;
    logic          w_timer_clr;
    logic [TW-1:0] w_terminal;
    logic          w_at_terminal;

    logic          r_short;
    logic          r_long;
    logic          r_dclick;
    logic          r_pressed;
    logic          r_busy;
    logic [7:0]    r_event_count;

    btn_cycle_timer #(
        .TW(TW)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_timer_clr),
        .i_enable     (w_timer_en),
        .i_terminal   (w_terminal),
        .o_at_terminal(w_at_terminal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_short      = 1'b0;
        w_long       = 1'b0;
        w_dclick     = 1'b0;
        w_timer_en   = 1'b0;
        w_terminal   = LONG_TERM;
        case (r_state)
            IDLE: begin
                if (btn_level) w_state_next = PRESS1;
            end
            PRESS1: begin
                if (btn_level) begin
                    w_timer_en = 1'b1;
                    if (w_at_terminal) begin
                        w_long       = 1'b1;
                        w_state_next = HOLD;
                    end
                end else begin
                    w_state_next = WAIT2;
                end
            end
            WAIT2: begin
                w_terminal = DCLICK_TERM;
                if (!btn_level) begin
                    w_timer_en = 1'b1;
                    if (w_at_terminal) begin
                        w_short      = 1'b1;
                        w_state_next = IDLE;
                    end
                end else begin
                    w_state_next = PRESS2;
                end
            end
            PRESS2: begin
                if (!btn_level) begin
                    w_dclick     = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_timer_en = 1'b1;
                    // first click was short, this one is long: report both
                    if (w_at_terminal) begin
                        w_short      = 1'b1;
                        w_long       = 1'b1;
                        w_state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!btn_level) w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_timer_clr = (w_state_next != r_state) || (r_state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_short       <= 1'b0;
            r_long        <= 1'b0;
            r_dclick      <= 1'b0;
            r_pressed     <= 1'b0;
            r_busy        <= 1'b0;
            r_event_count <= 8'd0;
        end else begin
            r_short       <= w_short;
            r_long        <= w_long;
            r_dclick      <= w_dclick;
            r_pressed     <= btn_level;
            r_busy        <= (w_state_next != IDLE);
            r_event_count <= r_event_count + {7'd0, w_short} + {7'd0, w_long}
                             + {7'd0, w_dclick};
        end
    end

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign double_click = r_dclick;
    assign pressed      = r_pressed;
    assign busy         = r_busy;
    assign event_count  = r_event_count;

endmodule

// File: tb/tb_button_event_fsm.sv
// Self-checking bench for button_event_fsm: directed scenarios plus random
// button traffic compared against a run-length based classification model.
module tb_button_event_fsm;

    localparam int L    = 8;
    localparam int D    = 4;
    localparam int MAXN = 2048;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_level;
    logic       short_press;
    logic       long_press;
    logic       double_click;
    logic       pressed;
    logic       busy;
    logic [7:0] event_count;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus samples (one per rising edge) and expectations after each edge
    bit          stim [MAXN];
    int          n;
    bit          e_short [MAXN];
    bit          e_long [MAXN];
    bit          e_dclick [MAXN];
    bit          e_busy [MAXN];
    int          e_count [MAXN];
    logic [12:0] obs [MAXN];

    button_event_fsm #(
        .LONG_CYCLES  (L),
        .DCLICK_CYCLES(D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_level   (btn_level),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click),
        .pressed     (pressed),
        .busy        (busy),
        .event_count (event_count)
    );

    always #5 clk = ~clk;

    task automatic fill(input bit v, input int len);
        for (int i = 0; i < len; i++) begin
            if (n < MAXN) begin
                stim[n] = v;
                n++;
            end
        end
    endtask

    function automatic int run_len(input int from, input bit v);
        int c = 0;
        while ((from + c < n) && (stim[from + c] == v)) c++;
        return c;
    endfunction

    task automatic mark_busy(input int first, input int last);
        for (int k = first; k <= last; k++) if (k < n) e_busy[k] = 1'b1;
    endtask

    // Walks the sample list press by press, measuring run lengths against the
    // long and double-click thresholds.
    task automatic build_model();
        int i = 0;
        int a, h, r, l, p, h2, z, c;
        for (int k = 0; k < MAXN; k++) begin
            e_short[k] = 0; e_long[k] = 0; e_dclick[k] = 0; e_busy[k] = 0; e_count[k] = 0;
        end
        while (i < n) begin
            if (!stim[i]) begin
                i++;
            end else begin
                a = i;
                h = run_len(a, 1'b1);
                if (h >= L) begin
                    if (a + L - 1 < n) e_long[a + L - 1] = 1'b1;
                    mark_busy(a, a + h - 1);
                    i = a + h + 1;
                end else begin
                    r = a + h;
                    l = run_len(r, 1'b0);
                    if (l >= D) begin
                        if (r + D - 1 < n) e_short[r + D - 1] = 1'b1;
                        mark_busy(a, r + D - 2);
                        i = r + D;
                    end else begin
                        p  = r + l;
                        h2 = run_len(p, 1'b1);
                        if (h2 >= L) begin
                            if (p + L - 1 < n) begin
                                e_short[p + L - 1] = 1'b1;
                                e_long[p + L - 1]  = 1'b1;
                            end
                            mark_busy(a, p + h2 - 1);
                            i = p + h2 + 1;
                        end else begin
                            z = p + h2;
                            if (z < n) e_dclick[z] = 1'b1;
                            mark_busy(a, z - 1);
                            i = z + 1;
                        end
                    end
                end
            end
        end
        c = 0;
        for (int k = 0; k < n; k++) begin
            c = c + int'(e_short[k]) + int'(e_long[k]) + int'(e_dclick[k]);
            e_count[k] = c % 256;
        end
    endtask

    function automatic logic [12:0] exp_vec(input int k);
        logic [7:0] cnt;
        cnt = 8'(e_count[k]);
        return {e_short[k], e_long[k], e_dclick[k], e_busy[k], stim[k], cnt};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        btn_level = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_samples();
        for (int k = 0; k < n; k++) begin
            btn_level = stim[k];
            @(posedge clk);
            @(negedge clk);
            obs[k] = {short_press, long_press, double_click, busy, pressed, event_count};
        end
    endtask

    task automatic test_reset();
        logic [12:0] now;
        apply_reset();
        now = {short_press, long_press, double_click, busy, pressed, event_count};
        n_checks++;
        if (now !== 13'd0) begin
            n_errors++;
            $display("FAIL reset_state got=%b want=%b", now, 13'd0);
        end
        btn_level = 1'b1;
        repeat ($urandom_range(2, 5)) @(negedge clk);
        #2 reset = 1'b1;
        #1 now = {short_press, long_press, double_click, busy, pressed, event_count};
        n_checks++;
        if (now !== 13'd0) begin
            n_errors++;
            $display("FAIL async_reset got=%b want=%b", now, 13'd0);
        end
        @(negedge clk);
        reset     = 1'b0;
        btn_level = 1'b0;
        $display("test_reset: done");
    endtask

    task automatic test_short();
        apply_reset();
        n = 0; fill(1'b1, 3); fill(1'b0, 8);
        build_model(); run_samples();
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL short_trace cyc=%0d got=%b want=%b", k, obs[k], exp_vec(k));
            end
        end
        n_checks++;
        if (obs[6][12] !== 1'b1 || obs[n-1][7:0] !== 8'd1) begin
            n_errors++;
            $display("FAIL short_spot got=%b/%0d want=1/1", obs[6][12], obs[n-1][7:0]);
        end
        $display("test_short: short at cycle 6, count=%0d", obs[n-1][7:0]);
    endtask

    task automatic test_long();
        apply_reset();
        n = 0; fill(1'b1, 12); fill(1'b0, 4);
        build_model(); run_samples();
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL long_trace cyc=%0d got=%b want=%b", k, obs[k], exp_vec(k));
            end
        end
        n_checks++;
        if (obs[7][11] !== 1'b1 || obs[11][9] !== 1'b1 || obs[12][9] !== 1'b0) begin
            n_errors++;
            $display("FAIL long_spot got=long%b busy%b%b want=long1 busy10", obs[7][11],
                     obs[11][9], obs[12][9]);
        end
        $display("test_long: long at cycle 7, count=%0d", obs[n-1][7:0]);
    endtask

    task automatic test_double();
        apply_reset();
        n = 0; fill(1'b1, 2); fill(1'b0, 2); fill(1'b1, 2); fill(1'b0, 6);
        build_model(); run_samples();
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL double_trace cyc=%0d got=%b want=%b", k, obs[k], exp_vec(k));
            end
        end
        n_checks++;
        if (obs[6][10] !== 1'b1 || obs[n-1][7:0] !== 8'd1) begin
            n_errors++;
            $display("FAIL double_spot got=%b/%0d want=1/1", obs[6][10], obs[n-1][7:0]);
        end
        $display("test_double: double click at cycle 6, count=%0d", obs[n-1][7:0]);
    endtask

    task automatic test_click_long();
        apply_reset();
        n = 0; fill(1'b1, 2); fill(1'b0, 2); fill(1'b1, 10); fill(1'b0, 3);
        build_model(); run_samples();
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL click_long_trace cyc=%0d got=%b want=%b", k, obs[k], exp_vec(k));
            end
        end
        n_checks++;
        if (obs[11][12:11] !== 2'b11 || obs[n-1][7:0] !== 8'd2) begin
            n_errors++;
            $display("FAIL click_long_spot got=%b/%0d want=11/2", obs[11][12:11], obs[n-1][7:0]);
        end
        $display("test_click_long: short+long at cycle 11, count=%0d", obs[n-1][7:0]);
    endtask

    task automatic test_reset_mid();
        logic [12:0] now;
        apply_reset();
        n = 0; fill(1'b1, 5);
        run_samples();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1 now = {short_press, long_press, double_click, busy, pressed, event_count};
            n_checks++;
            if (now !== 13'd0) begin
                n_errors++;
                $display("FAIL reset_mid_hold step=%0d got=%b want=%b", c, now, 13'd0);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        n = 0; fill(1'b1, 12); fill(1'b0, 3);
        build_model(); run_samples();
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL reset_mid_trace cyc=%0d got=%b want=%b", k, obs[k], exp_vec(k));
            end
        end
        n_checks++;
        if (obs[2][11] !== 1'b0 || obs[7][11] !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid_spot got=%b%b want=01", obs[2][11], obs[7][11]);
        end
        $display("test_reset_mid: long after 8 fresh samples");
    endtask

    task automatic test_wrap();
        apply_reset();
        n = 0;
        for (int c = 0; c < 257; c++) begin
            fill(1'b1, 1); fill(1'b0, D);
        end
        build_model(); run_samples();
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL wrap_trace cyc=%0d got=%b want=%b", k, obs[k], exp_vec(k));
            end
        end
        n_checks++;
        if (obs[n-1][7:0] !== 8'd1) begin
            n_errors++;
            $display("FAIL wrap_count got=%0d want=1", obs[n-1][7:0]);
        end
        $display("test_wrap: 257 clicks, count=%0d", obs[n-1][7:0]);
    endtask

    task automatic test_random();
        int events = 0;
        apply_reset();
        n = 0;
        while (n < 700) begin
            fill(1'b1, $urandom_range(1, 11));
            fill(1'b0, $urandom_range(1, 7));
        end
        build_model(); run_samples();
        for (int k = 0; k < n; k++) begin
            events += int'(e_short[k]) + int'(e_long[k]) + int'(e_dclick[k]);
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
                n_errors++;
                $display("FAIL random_trace cyc=%0d got=%b want=%b", k, obs[k], exp_vec(k));
            end
        end
        $display("test_random: %0d cycles, %0d events expected", n, events);
    endtask

    initial begin
        reset     = 1'b1;
        btn_level = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_double();
        test_click_long();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
